// File: rtl/seg7_scan_if.sv
// Bus bundle between a multiplexed 7-segment display tap and the scan decoder.
// Master side drives the display pins; slave side is the decoder.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    err_clr;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic [2:0]              update_idx;
  logic                    err_pattern;
  logic                    err_anode;

  modport master (
    output seg_n, an_n, err_clr,
    input  digits, digit_valid, update,
    input  update_idx, err_pattern, err_anode
  );

  modport slave (
    input  seg_n, an_n, err_clr,
    output digits, digit_valid, update,
    output update_idx, err_pattern, err_anode
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit codes from a multiplexed active-low 7-segment bus.
// Optional: define SEG7_DECODE_HEX_EN to also accept A..F glyphs.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input logic       clk,
  input logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int SW = NUM_DIGITS + 7;
  localparam int CW =
    (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  logic [SW-1:0]           r_s1, r_s2, r_prev;
  logic [CW-1:0]           r_cnt;
  state_t                  r_state, w_next;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_update;
  logic [2:0]              r_idx;
  logic                    r_errp, r_erra;

  logic                  w_chg, w_cap, w_an_idle;
  logic [NUM_DIGITS-1:0] w_low;
  logic [3:0]            w_nlow;
  logic [2:0]            w_idx;
  logic [4:0]            w_dec;
  logic                  w_blank, w_one, w_set_p, w_set_a;

  // {ok, code}; ok=0 for anything that is not a known glyph
  function automatic logic [4:0] f_dec(input logic [6:0] p);
    case (p)
      7'h40: f_dec = {1'b1, 4'h0};
      7'h79: f_dec = {1'b1, 4'h1};
      7'h24: f_dec = {1'b1, 4'h2};
      7'h30: f_dec = {1'b1, 4'h3};
      7'h19: f_dec = {1'b1, 4'h4};
      7'h12: f_dec = {1'b1, 4'h5};
      7'h02: f_dec = {1'b1, 4'h6};
      7'h78: f_dec = {1'b1, 4'h7};
      7'h00: f_dec = {1'b1, 4'h8};
      7'h10: f_dec = {1'b1, 4'h9};
`ifdef SEG7_DECODE_HEX_EN
      7'h08: f_dec = {1'b1, 4'hA};
      7'h03: f_dec = {1'b1, 4'hB};
      7'h46: f_dec = {1'b1, 4'hC};
      7'h21: f_dec = {1'b1, 4'hD};
      7'h06: f_dec = {1'b1, 4'hE};
      7'h0E: f_dec = {1'b1, 4'hF};
`endif
      default: f_dec = 5'd0;
    endcase
  endfunction

  assign w_low     = ~r_s2[SW-1:7];
  assign w_an_idle = (w_low == '0);
  assign w_chg     = (r_s2 != r_prev);
  assign w_dec     = f_dec(r_s2[6:0]);
  assign w_blank   = (r_s2[6:0] == 7'h7F);

  always_comb begin
    w_nlow = 4'd0;
    w_idx  = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_low[i]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = 3'(i);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_chg && !w_an_idle) w_next = SETTLE;
      end
      SETTLE: begin
        if (!w_chg && r_cnt == CMAX) begin
          w_cap  = 1'b1;
          w_next = HOLD;
        end
      end
      HOLD: begin
        if (w_chg) w_next = w_an_idle ? IDLE : SETTLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_one   = w_cap && (w_nlow == 4'd1);
  assign w_set_p = w_one && !w_dec[4] && !w_blank;
  assign w_set_a = w_cap && (w_nlow > 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_prev  <= '1;
      r_cnt   <= '0;
      r_state <= IDLE;
    end else begin
      r_s1    <= {bus.an_n, bus.seg_n};
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_state <= w_next;
      if (w_chg)
        r_cnt <= '0;
      else if (r_cnt != CMAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_update <= 1'b0;
      r_idx    <= 3'd0;
      r_errp   <= 1'b0;
      r_erra   <= 1'b0;
    end else begin
      r_update <= w_one;
      r_errp   <= (r_errp & ~bus.err_clr) | w_set_p;
      r_erra   <= (r_erra & ~bus.err_clr) | w_set_a;
      if (w_one) r_idx <= w_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_one && w_low[i]) begin
          r_valid[i] <= w_dec[4];
          if (w_dec[4]) r_digits[4*i +: 4] <= w_dec[3:0];
        end
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.digit_valid = r_valid;
  assign bus.update      = r_update;
  assign bus.update_idx  = r_idx;
  assign bus.err_pattern = r_errp;
  assign bus.err_anode   = r_erra;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed display traffic, queued
// expected updates checked by an independent monitor.
module tb_seg7_scan_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         at;
    logic [2:0] idx;
    logic [3:0] val;
    logic       vld;
  } exp_t;
  exp_t q[$];

  seg7_scan_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'h40;
      1: enc = 7'h79;
      2: enc = 7'h24;
      3: enc = 7'h30;
      4: enc = 7'h19;
      5: enc = 7'h12;
      6: enc = 7'h02;
      7: enc = 7'h78;
      8: enc = 7'h00;
      9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // pins change now; capture pulse expected 19 posedges later
  task automatic expect_upd(input int idx, input int v, input bit vld);
    exp_t e;
    e.at  = cyc + 19;
    e.idx = 3'(idx);
    e.val = 4'(v);
    e.vld = vld;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg);
    bus.an_n  = an;
    bus.seg_n = sg;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.update) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: idx %0d at cyc %0d",
                 bus.update_idx, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_cycle", cyc, e.at);
        chk("upd_idx", bus.update_idx, e.idx);
        chk("upd_digit", bus.digits[4*e.idx +: 4], e.val);
        chk("upd_valid", bus.digit_valid[e.idx], e.vld);
      end
    end
  end

  initial begin
    drive(4'hF, 7'h7F);
    bus.err_clr = 1'b0;
    step(3);
    chk("rst_digits", bus.digits, 0);
    chk("rst_valid", bus.digit_valid, 0);
    chk("rst_update", bus.update, 0);
    chk("rst_errs", {bus.err_pattern, bus.err_anode}, 0);
    rst_n = 1'b1;
    step(2);

    // digit 3 on slot 2
    drive(4'b1011, 7'h30);
    expect_upd(2, 3, 1);
    step(40);
    chk("d3_digit", bus.digits[11:8], 3);
    chk("d3_valid", bus.digit_valid, 4'b0100);

    // glitchy start on slot 0
    drive(4'b1110, 7'h40);
    step(10);
    drive(4'b1110, 7'h79);
    expect_upd(0, 1, 1);
    step(30);
    chk("glitch_digit", bus.digits[3:0], 1);

    // 8, then blank, then an invalid glyph
    drive(4'b1110, 7'h00);
    expect_upd(0, 8, 1);
    step(30);
    drive(4'b1110, 7'h7F);
    expect_upd(0, 8, 0);
    step(30);
    chk("blank_digit", bus.digits[3:0], 8);
    chk("blank_valid", bus.digit_valid[0], 0);
    chk("blank_noerr", bus.err_pattern, 0);
    drive(4'b1110, 7'h7E);
    expect_upd(0, 8, 0);
    step(30);
    chk("bad_errp", bus.err_pattern, 1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    chk("errclr", bus.err_pattern, 0);

    // two anodes low
    drive(4'b0011, 7'h40);
    step(25);
    chk("dbl_erra", bus.err_anode, 1);
    chk("dbl_digits", bus.digits, 16'h0308);
    chk("dbl_valid", bus.digit_valid, 4'b0100);

    // scan 1,9,0,5 across slots 0..3
    drive(4'b1110, enc(1)); expect_upd(0, 1, 1); step(40);
    drive(4'b1101, enc(9)); expect_upd(1, 9, 1); step(40);
    drive(4'b1011, enc(0)); expect_upd(2, 0, 1); step(40);
    drive(4'b0111, enc(5)); expect_upd(3, 5, 1); step(40);
    chk("scan_digits", bus.digits, 16'h5091);
    chk("scan_valid", bus.digit_valid, 4'hF);

    // reset partway through a settle window
    drive(4'b1101, enc(7));
    step(10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", bus.digits, 0);
    chk("mid_rst_valid", bus.digit_valid, 0);
    chk("mid_rst_idx", bus.update_idx, 0);
    chk("mid_rst_erra", bus.err_anode, 0);
    step(3);
    rst_n = 1'b1;
    expect_upd(1, 7, 1);
    step(30);
    chk("post_rst_digits", bus.digits, 16'h0070);
    chk("post_rst_valid", bus.digit_valid, 4'b0010);

    // hex glyph A on slot 1
    drive(4'b1101, 7'h08);
`ifdef SEG7_DECODE_HEX_EN
    expect_upd(1, 10, 1);
    step(30);
    chk("hex_errp", bus.err_pattern, 0);
    chk("hex_digit", bus.digits[7:4], 4'hA);
`else
    expect_upd(1, 7, 0);
    step(30);
    chk("hex_errp", bus.err_pattern, 1);
    chk("hex_digit", bus.digits[7:4], 4'h7);
`endif

    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
